// File: rtl/chan_initial_select.sv
`default_nettype none
// ============================================================================
// Module      : chan_initial_select
// Description : Channel-side initial-selection sequencer for one bus-and-tag
//               interface. Define CHAN_PARITY_CHECK_EN to check bus-in parity.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_initial_select #(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] device_address,
    input  logic [7:0] command,
    output logic       busy,
    output logic       done,
    output logic [2:0] error,
    output logic [7:0] status,
    output logic [7:0] bus_out,
    output logic       bus_out_parity,
    input  logic [7:0] bus_in,
    input  logic       bus_in_parity,
    output logic       operational_out,
    output logic       hold_out,
    output logic       select_out,
    output logic       address_out,
    output logic       command_out,
    output logic       service_out,
    input  logic       operational_in,
    input  logic       address_in,
    input  logic       status_in,
    input  logic       select_in
);

    localparam int c_tmr_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_setup_w = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    localparam logic [c_tmr_w-1:0]   c_tmr_load  = c_tmr_w'(TIMEOUT_CYCLES);
    localparam logic [c_tmr_w-1:0]   c_tmr_one   = c_tmr_w'(1);
    localparam logic [c_setup_w-1:0] c_setup_last = c_setup_w'(SETUP_CYCLES - 1);

    localparam logic [3:0] c_idle       = 4'd0;
    localparam logic [3:0] c_addr_setup = 4'd1;
    localparam logic [3:0] c_select     = 4'd2;
    localparam logic [3:0] c_addr_ack   = 4'd3;
    localparam logic [3:0] c_cmd_setup  = 4'd4;
    localparam logic [3:0] c_cmd        = 4'd5;
    localparam logic [3:0] c_status     = 4'd6;
    localparam logic [3:0] c_svc        = 4'd7;
    localparam logic [3:0] c_release    = 4'd8;

    localparam logic [2:0] c_err_ok       = 3'd0;
    localparam logic [2:0] c_err_nodev    = 3'd1;
    localparam logic [2:0] c_err_mismatch = 3'd2;
    localparam logic [2:0] c_err_parity   = 3'd3;
    localparam logic [2:0] c_err_timeout  = 3'd4;
    localparam logic [2:0] c_err_busy     = 3'd5;

    logic [3:0]           r_state, w_state_nxt;
    logic [2:0]           w_fail;
    logic [c_tmr_w-1:0]   r_tmr;
    logic [c_setup_w-1:0] r_setup;
    logic                 r_deskew, r_par_err;
    logic [7:0]           r_addr, r_cmd;

    logic [3:0] r_tag_meta, r_tag_sync;
    logic [7:0] r_bus_meta, r_bus_sync;

    logic       r_busy, r_done, r_bus_par, r_op_out, r_hold, r_sel;
    logic       r_addr_out, r_cmd_out, r_svc;
    logic [2:0] r_error;
    logic [7:0] r_status, r_bus_out;

    logic       w_busy_nxt, w_done_nxt, w_hold_nxt, w_sel_nxt;
    logic       w_addr_out_nxt, w_cmd_out_nxt, w_svc_nxt;
    logic [2:0] w_error_nxt;
    logic [7:0] w_status_nxt, w_bus_out_nxt;

    logic w_op_in, w_addr_in, w_stat_in, w_sel_in;
    logic w_accept, w_expire, w_setup_done, w_par_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_meta <= '0;
            r_tag_sync <= '0;
            r_bus_meta <= '0;
            r_bus_sync <= '0;
        end else begin
            r_tag_meta <= {select_in, status_in, address_in, operational_in};
            r_tag_sync <= r_tag_meta;
            r_bus_meta <= bus_in;
            r_bus_sync <= r_bus_meta;
        end
    end

`ifdef CHAN_PARITY_CHECK_EN
    logic r_par_meta, r_par_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_meta <= 1'b0;
            r_par_sync <= 1'b0;
        end else begin
            r_par_meta <= bus_in_parity;
            r_par_sync <= r_par_meta;
        end
    end

    assign w_par_bad = ~(^{r_bus_sync, r_par_sync});
`else
    logic w_unused_par;
    assign w_unused_par = bus_in_parity;
    assign w_par_bad    = 1'b0;
`endif

    assign w_op_in      = r_tag_sync[0];
    assign w_addr_in    = r_tag_sync[1];
    assign w_stat_in    = r_tag_sync[2];
    assign w_sel_in     = r_tag_sync[3];
    assign w_accept     = start & enable & (r_state == c_idle);
    // Expires on the cycle the count would reach zero, so the release lands
    // exactly TIMEOUT_CYCLES after the waiting state was entered.
    assign w_expire     = (r_tmr <= c_tmr_one);
    assign w_setup_done = (r_setup == c_setup_last);

    // State and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_tmr      <= c_tmr_load;
            r_setup    <= '0;
            r_deskew   <= 1'b0;
            r_par_err  <= 1'b0;
            r_addr     <= '0;
            r_cmd      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= '0;
            r_status   <= '0;
            r_bus_out  <= '0;
            r_bus_par  <= 1'b0;
            r_op_out   <= 1'b0;
            r_hold     <= 1'b0;
            r_sel      <= 1'b0;
            r_addr_out <= 1'b0;
            r_cmd_out  <= 1'b0;
            r_svc      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_tmr    <= c_tmr_load;
                r_setup  <= '0;
                r_deskew <= 1'b0;
            end else begin
                if (r_tmr != '0)
                    r_tmr <= r_tmr - 1'b1;
                r_setup <= r_setup + 1'b1;
                if (r_state == c_status && w_stat_in)
                    r_deskew <= 1'b1;
            end
            if (w_accept) begin
                r_addr    <= device_address;
                r_cmd     <= command;
                r_par_err <= 1'b0;
            end else if (r_state == c_status && r_deskew) begin
                r_par_err <= w_par_bad;
            end
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_status   <= w_status_nxt;
            r_bus_out  <= w_bus_out_nxt;
            r_bus_par  <= ~(^w_bus_out_nxt);
            r_op_out   <= enable;
            r_hold     <= w_hold_nxt;
            r_sel      <= w_sel_nxt;
            r_addr_out <= w_addr_out_nxt;
            r_cmd_out  <= w_cmd_out_nxt;
            r_svc      <= w_svc_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_fail      = c_err_ok;
        case (r_state)
            c_idle: begin
                if (w_accept && !w_op_in)
                    w_state_nxt = c_addr_setup;
            end
            c_addr_setup: begin
                if (w_setup_done)
                    w_state_nxt = c_select;
            end
            c_select: begin
                if (w_op_in && w_addr_in) begin
                    w_state_nxt = c_addr_ack;
                end else if (w_sel_in) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_nodev;
                end else if (w_expire) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_timeout;
                end
            end
            c_addr_ack: begin
                if (w_par_bad) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_parity;
                end else if (r_bus_sync != r_addr) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_mismatch;
                end else begin
                    w_state_nxt = c_cmd_setup;
                end
            end
            c_cmd_setup: begin
                if (w_setup_done)
                    w_state_nxt = c_cmd;
            end
            c_cmd: begin
                if (!w_addr_in) begin
                    w_state_nxt = c_status;
                end else if (w_expire) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_timeout;
                end
            end
            c_status: begin
                // Bus-in is taken one cycle after status-in is seen
                if (r_deskew) begin
                    w_state_nxt = c_svc;
                end else if (!w_stat_in && w_expire) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_timeout;
                end
            end
            c_svc: begin
                if (!w_stat_in) begin
                    w_state_nxt = c_release;
                    w_fail      = r_par_err ? c_err_parity : c_err_ok;
                end else if (w_expire) begin
                    w_state_nxt = c_release;
                    w_fail      = c_err_timeout;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
        if (!enable && r_state != c_idle && r_state != c_release) begin
            w_state_nxt = c_release;
            w_fail      = c_err_timeout;
        end
    end

    // Output next-value logic
    always_comb begin
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_status_nxt   = r_status;
        w_bus_out_nxt  = r_bus_out;
        w_hold_nxt     = r_hold;
        w_sel_nxt      = r_sel;
        w_addr_out_nxt = r_addr_out;
        w_cmd_out_nxt  = r_cmd_out;
        w_svc_nxt      = r_svc;
        case (r_state)
            c_idle: begin
                if (w_accept) begin
                    w_error_nxt  = c_err_ok;
                    w_status_nxt = '0;
                    if (w_op_in) begin
                        w_done_nxt  = 1'b1;
                        w_error_nxt = c_err_busy;
                    end else begin
                        w_busy_nxt    = 1'b1;
                        w_bus_out_nxt = device_address;
                    end
                end
            end
            c_addr_setup: begin
                if (w_state_nxt == c_select) begin
                    w_addr_out_nxt = 1'b1;
                    w_hold_nxt     = 1'b1;
                    w_sel_nxt      = 1'b1;
                end
            end
            c_addr_ack: begin
                if (w_state_nxt == c_cmd_setup) begin
                    w_addr_out_nxt = 1'b0;
                    w_bus_out_nxt  = r_cmd;
                end
            end
            c_cmd_setup: begin
                if (w_state_nxt == c_cmd)
                    w_cmd_out_nxt = 1'b1;
            end
            c_cmd: begin
                if (w_state_nxt == c_status)
                    w_cmd_out_nxt = 1'b0;
            end
            c_status: begin
                if (w_state_nxt == c_svc) begin
                    w_svc_nxt    = 1'b1;
                    w_status_nxt = r_bus_sync;
                end
            end
            default: ;
        endcase
        if (w_state_nxt == c_release && r_state != c_release) begin
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
            w_error_nxt    = w_fail;
            w_bus_out_nxt  = '0;
            w_hold_nxt     = 1'b0;
            w_sel_nxt      = 1'b0;
            w_addr_out_nxt = 1'b0;
            w_cmd_out_nxt  = 1'b0;
            w_svc_nxt      = 1'b0;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign status          = r_status;
    assign bus_out         = r_bus_out;
    assign bus_out_parity  = r_bus_par;
    assign operational_out = r_op_out;
    assign hold_out        = r_hold;
    assign select_out      = r_sel;
    assign address_out     = r_addr_out;
    assign command_out     = r_cmd_out;
    assign service_out     = r_svc;

endmodule
`default_nettype wire

// File: tb/tb_chan_initial_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_initial_select
// Description : Self-checking bench for chan_initial_select with a device
//               model and a done-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_initial_select;

    localparam int c_setup   = 4;
    localparam int c_timeout = 4096;
`ifdef CHAN_PARITY_CHECK_EN
    localparam logic [2:0] c_par_exp = 3'd3;
`else
    localparam logic [2:0] c_par_exp = 3'd0;
`endif
    localparam int c_sel = 0, c_addr = 1, c_cmd = 2, c_svc = 3, c_done = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0, start = 1'b0;
    logic [7:0] device_address = '0, command = '0;
    logic       busy, done;
    logic [2:0] error;
    logic [7:0] status, bus_out;
    logic       bus_out_parity;
    logic [7:0] bus_in = '0;
    logic       bus_in_parity = 1'b0;
    logic       operational_out, hold_out, select_out, address_out, command_out, service_out;
    logic       operational_in = 1'b0, address_in = 1'b0, status_in = 1'b0, select_in = 1'b0;

    chan_initial_select #(.SETUP_CYCLES(c_setup), .TIMEOUT_CYCLES(c_timeout)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .device_address(device_address), .command(command),
        .busy(busy), .done(done), .error(error), .status(status),
        .bus_out(bus_out), .bus_out_parity(bus_out_parity),
        .bus_in(bus_in), .bus_in_parity(bus_in_parity),
        .operational_out(operational_out), .hold_out(hold_out), .select_out(select_out),
        .address_out(address_out), .command_out(command_out), .service_out(service_out),
        .operational_in(operational_in), .address_in(address_in),
        .status_in(status_in), .select_in(select_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] err;
        logic [7:0] stat;
        logic       chk_stat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   addr_fall_cyc = 0, cmd_rise_cyc = 0, svc_rise_cyc = 0, done_cyc = 0, cmd_rises = 0;
    logic prev_addr = 1'b0, prev_cmd = 1'b0, prev_svc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
            e = sb.pop_front();
            check("done_error", {29'd0, error}, {29'd0, e.err});
            if (e.chk_stat)
                check("done_status", {24'd0, status}, {24'd0, e.stat});
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Edge-time recorder and scoreboard consumer
    always @(negedge clk) begin
        prev_addr <= address_out;
        prev_cmd  <= command_out;
        prev_svc  <= service_out;
        if (prev_addr && !address_out) addr_fall_cyc <= cyc;
        if (!prev_cmd && command_out) begin
            cmd_rise_cyc <= cyc;
            cmd_rises    <= cmd_rises + 1;
        end
        if (!prev_svc && service_out) svc_rise_cyc <= cyc;
        if (done) begin
            done_cyc <= cyc;
            sb_pop_check();
        end
    end

    function automatic logic out_sig(input int idx);
        case (idx)
            c_sel:   return select_out;
            c_addr:  return address_out;
            c_cmd:   return command_out;
            c_svc:   return service_out;
            c_done:  return done;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [27:0] all_outs();
        return {busy, done, error, status, bus_out, bus_out_parity, operational_out,
                hold_out, select_out, address_out, command_out, service_out};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input int idx, input logic val, input int budget, input string tag);
        int i = 0;
        while (out_sig(idx) !== val && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check(tag, {31'd0, out_sig(idx)}, {31'd0, val});
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] c, input logic [2:0] e,
                            input logic [7:0] s, input logic chk_s);
        exp_t x;
        x.err = e; x.stat = s; x.chk_stat = chk_s;
        sb.push_back(x);
        device_address = a;
        command = c;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic idle_gap();
        operational_in = 1'b0; address_in = 1'b0; status_in = 1'b0; select_in = 1'b0;
        bus_in = '0; bus_in_parity = 1'b0;
        step(6);
    endtask

    task automatic run_sel(input string name, input logic [7:0] a, input logic [7:0] c,
                           input logic [7:0] echo, input logic [7:0] stat, input bit par_ok,
                           input bit hang, input bit poke, input logic [2:0] exp_err);
        int rises0;
        rises0 = cmd_rises;
        do_start(a, c, exp_err, stat, exp_err == 3'd0);
        wait_out(c_sel, 1'b1, 100, {name, "_select_out"});
        check({name, "_bus_addr"}, {24'd0, bus_out}, {24'd0, a});
        check({name, "_bus_par"}, {31'd0, bus_out_parity}, {31'd0, ~^a});
        operational_in = 1'b1; address_in = 1'b1;
        bus_in = echo; bus_in_parity = ~^echo;
        if (poke) begin
            device_address = 8'h99; command = 8'h77; start = 1'b1;
            step(1);
            start = 1'b0;
        end
        if (echo != a) begin
            wait_out(c_done, 1'b1, 100, {name, "_done"});
            @(negedge clk); #1;
            check({name, "_no_cmd_out"}, cmd_rises, rises0);
        end else begin
            wait_out(c_cmd, 1'b1, 100, {name, "_command_out"});
            check({name, "_bus_cmd"}, {24'd0, bus_out}, {24'd0, c});
            address_in = 1'b0;
            wait_out(c_cmd, 1'b0, 100, {name, "_command_drop"});
            bus_in = stat; bus_in_parity = par_ok ? ~^stat : ^stat; status_in = 1'b1;
            wait_out(c_svc, 1'b1, 100, {name, "_service_out"});
            if (!hang) status_in = 1'b0;
            wait_out(c_done, 1'b1, hang ? c_timeout + 200 : 100, {name, "_done"});
            check({name, "_svc_at_done"}, {31'd0, service_out}, 32'd0);
            check({name, "_tags_at_done"}, {30'd0, select_out, hold_out}, 32'd0);
            @(negedge clk); #1;
            check({name, "_cmd_setup"}, cmd_rise_cyc - addr_fall_cyc, c_setup);
            if (hang) check({name, "_timeout_len"}, done_cyc - svc_rise_cyc, c_timeout);
        end
        idle_gap();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(3);
        check("reset_outputs", {4'd0, all_outs()}, 32'd0);
        enable = 1'b1;
        reset  = 1'b0;
        step(3);
        check("operational_out_idle", {31'd0, operational_out}, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);

        run_sel("normal", 8'h0E, 8'h02, 8'h0E, 8'h0C, 1'b1, 1'b0, 1'b0, 3'd0);
        run_sel("busy_poke", 8'h21, 8'h05, 8'h21, 8'h40, 1'b1, 1'b0, 1'b1, 3'd0);

        // No device answers: select comes back around
        do_start(8'h0E, 8'h02, 3'd1, 8'h00, 1'b0);
        wait_out(c_sel, 1'b1, 100, "nodev_select_out");
        step(20);
        select_in = 1'b1;
        wait_out(c_done, 1'b1, 100, "nodev_done");
        check("nodev_tags", {29'd0, address_out, select_out, hold_out}, 32'd0);
        idle_gap();

        run_sel("mismatch", 8'h0E, 8'h02, 8'h0F, 8'h0C, 1'b1, 1'b0, 1'b0, 3'd2);
        run_sel("timeout", 8'h0E, 8'h02, 8'h0E, 8'h0C, 1'b1, 1'b1, 1'b0, 3'd4);

        // Device already operational when start arrives
        operational_in = 1'b1;
        step(4);
        do_start(8'h0E, 8'h02, 3'd5, 8'h00, 1'b0);
        wait_out(c_done, 1'b1, 10, "busy_done");
        check("busy_no_tags", {19'd0, bus_out, hold_out, select_out, address_out, command_out, service_out}, 32'd0);
        step(2);
        check("busy_stays_idle", {26'd0, busy, hold_out, select_out, address_out, command_out, service_out}, 32'd0);
        idle_gap();

        // Enable dropped while waiting for status
        do_start(8'h31, 8'h03, 3'd4, 8'h00, 1'b0);
        wait_out(c_sel, 1'b1, 100, "endrop_select_out");
        operational_in = 1'b1; address_in = 1'b1; bus_in = 8'h31; bus_in_parity = ~^8'h31;
        wait_out(c_cmd, 1'b1, 100, "endrop_command_out");
        address_in = 1'b0;
        wait_out(c_cmd, 1'b0, 100, "endrop_command_drop");
        enable = 1'b0;
        wait_out(c_done, 1'b1, 10, "endrop_done");
        check("endrop_tags", {29'd0, operational_out, select_out, hold_out}, 32'd0);
        enable = 1'b1;
        idle_gap();
        check("endrop_op_restored", {31'd0, operational_out}, 32'd1);

        // Reset while in the command phase
        do_start(8'h44, 8'h08, 3'd0, 8'h00, 1'b0);
        wait_out(c_sel, 1'b1, 100, "rst_select_out");
        operational_in = 1'b1; address_in = 1'b1; bus_in = 8'h44; bus_in_parity = ~^8'h44;
        wait_out(c_cmd, 1'b1, 100, "rst_command_out");
        #2;
        reset = 1'b1;
        #1;
        check("rst_outputs", {4'd0, all_outs()}, 32'd0);
        sb.delete();
        step(2);
        operational_in = 1'b0; address_in = 1'b0;
        reset = 1'b0;
        step(6);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);

        run_sel("parity", 8'h0E, 8'h02, 8'h0E, 8'h0C, 1'b0, 1'b0, 1'b0, c_par_exp);

        step(4);
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
